alu_result_queue: RTL and testbench
===================================

Name: alu_result_queue

Overview:
- Execute-to-writeback buffer directly downstream of the ALU.
- Captures each ALU result (alu_out, carry_out) with its destination register tag and write enable.
- Derives zero/negative flags and presents entries in order to the writeback stage over a valid/ready handshake.
- Decouples writeback stalls from the execute stage; supports pipeline flush on branch/exception.

Parameters:
- ALU_SIZE, 8, data width; matches the ALU data width.
- REG_ADDR_W, 5, destination register index width.
- DEPTH, 2, number of queue entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous flush; discards all entries at next edge.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  queue can accept; high when count < DEPTH.
- in_result  input  ALU_SIZE  ALU result.
- in_carry  input  1  ALU carry out.
- in_dest  input  REG_ADDR_W  destination register index.
- in_wr_en  input  1  result is to be written to the register file.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback accepts head entry.
- out_result  output  ALU_SIZE  head result.
- out_carry  output  1  head carry.
- out_zero  output  1  head result == 0.
- out_neg  output  1  head result MSB.
- out_dest  output  REG_ADDR_W  head destination index.
- out_wr_en  output  1  head write enable, after the r0 guard.
- count  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0; read/write pointers=0; all storage=0.
  - out_valid=0; out_result/out_carry/out_zero/out_neg/out_dest/out_wr_en=0.
  - in_ready=1.
- in_ready = (count < DEPTH). It is decoded from registered count only; no combinational path from out_ready.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- A push writes the entry at the write pointer. Flags are computed at push time:
  - zero = (in_result == 0)
  - neg = in_result[ALU_SIZE-1]
  - stored wr_en = in_wr_en & (in_dest != 0), so r0 is never written.
- out_* always reflect the entry at the read pointer. out_valid = (count != 0).
- Latency: a push into an empty queue appears on out_* with out_valid=1 on the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal whenever count is 1..DEPTH-1. At count==DEPTH, in_ready=0, so only the pop occurs.
- Pointers wrap modulo DEPTH. Entries are delivered in strict FIFO order.
- The head entry is held stable while out_valid & ~out_ready. The writeback stage may rely on that stability.
- flush high at an edge:
  - count, read pointer and write pointer go to 0 and out_valid=0 next cycle.
  - A push or pop requested in the same cycle is discarded. flush takes priority over everything except reset.
- Reset asserted mid-operation drops all entries immediately, asynchronously.
- Pushes with in_valid while in_ready=0 are ignored. Upstream must hold its data until accepted.

Optional Feature:
- Macro: ALU_RESULT_QUEUE_FWD_EN.
- Defined: adds a forwarding lookup for the operand fetch stage.
  - Added ports: fwd_addr_a, fwd_addr_b (input, REG_ADDR_W); fwd_hit_a, fwd_hit_b (output, 1); fwd_data_a, fwd_data_b (output, ALU_SIZE).
  - Combinationally search all valid entries for stored wr_en=1 and dest==fwd_addr_x.
  - On a match: fwd_hit_x=1 and fwd_data_x = the youngest matching entry's result.
  - Otherwise: hit=0, data=0. Address 0 never hits.
  - During reset or an empty queue, all fwd outputs are 0.
- Not defined: the fwd ports and lookup logic do not exist. Remaining behaviour is identical.

Test Plan:
- Reset then single push (result=8'h00, dest=3, wr_en=1), out_ready=1 -> next cycle out_valid=1, out_zero=1, out_neg=0, out_dest=3, out_wr_en=1; following cycle out_valid=0, count=0.
- Push 8'h80, then 8'h05, with out_ready=0 -> count=2, in_ready=0. A third push of 8'h11 is ignored. Head stays 8'h80 with out_neg=1. Raise out_ready -> 8'h80 then 8'h05 pop in order, then out_valid=0.
- Continuous push+pop for 10 cycles at count=1 (values 1..10) -> count stays 1; outputs 1..10 in order, one cycle behind; pointers wrap with no loss.
- Push with dest=0, wr_en=1, result 8'hFF -> out_wr_en=0, out_neg=1, out_result=8'hFF.
- Fill to 2, then assert flush together with in_valid (8'h22) -> next cycle count=0, out_valid=0, in_ready=1; 8'h22 is never delivered.
- ALU_RESULT_QUEUE_FWD_EN defined: queue holds {dest=4, 8'h10} then {dest=4, 8'h20}; fwd_addr_a=4, fwd_addr_b=0 -> fwd_hit_a=1, fwd_data_a=8'h20, fwd_hit_b=0. Assert rst_n=0 mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_result_queue.sv
// Execute-to-writeback result FIFO with zero/negative flag capture and an r0 write guard.
// Optional forwarding lookup for operand fetch is enabled by defining ALU_RESULT_QUEUE_FWD_EN.
module alu_result_queue #(
   parameter int ALU_SIZE   = 8,
   parameter int REG_ADDR_W = 5,
   parameter int DEPTH      = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ALU_SIZE-1:0]          in_result,
   input  logic                         in_carry,
   input  logic [REG_ADDR_W-1:0]        in_dest,
   input  logic                         in_wr_en,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ALU_SIZE-1:0]          out_result,
   output logic                         out_carry,
   output logic                         out_zero,
   output logic                         out_neg,
   output logic [REG_ADDR_W-1:0]        out_dest,
   output logic                         out_wr_en,
`ifdef ALU_RESULT_QUEUE_FWD_EN
   input  logic [REG_ADDR_W-1:0]        fwd_addr_a,
   input  logic [REG_ADDR_W-1:0]        fwd_addr_b,
   output logic                         fwd_hit_a,
   output logic                         fwd_hit_b,
   output logic [ALU_SIZE-1:0]          fwd_data_a,
   output logic [ALU_SIZE-1:0]          fwd_data_b,
`endif
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [ALU_SIZE-1:0]   mem_result_r [DEPTH];
   logic [REG_ADDR_W-1:0] mem_dest_r   [DEPTH];
   logic                  mem_carry_r  [DEPTH];
   logic                  mem_zero_r   [DEPTH];
   logic                  mem_neg_r    [DEPTH];
   logic                  mem_wr_en_r  [DEPTH];

   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_s;
   logic             pop_s;

   // Register index 0 is hardwired, so a write to it is dropped at capture time.
   function automatic logic guard_wr_en(input logic wr_en, input logic [REG_ADDR_W-1:0] dest);
      return wr_en & (dest != {REG_ADDR_W{1'b0}});
   endfunction

   function automatic logic is_zero(input logic [ALU_SIZE-1:0] value);
      return (value == {ALU_SIZE{1'b0}});
   endfunction

   assign in_ready  = (count_r < DEPTH_C);
   assign out_valid = (count_r != {CNT_W{1'b0}});
   assign push_s    = in_valid & in_ready;
   assign pop_s     = out_valid & out_ready;
   assign count     = count_r;

   assign out_result = mem_result_r[rd_ptr_r];
   assign out_carry  = mem_carry_r[rd_ptr_r];
   assign out_zero   = mem_zero_r[rd_ptr_r];
   assign out_neg    = mem_neg_r[rd_ptr_r];
   assign out_dest   = mem_dest_r[rd_ptr_r];
   assign out_wr_en  = mem_wr_en_r[rd_ptr_r];

   // Pointer and occupancy tracking; flush overrides any same-cycle push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; flags are derived once at capture so the head needs no extra logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_result_r[i] <= {ALU_SIZE{1'b0}};
            mem_dest_r[i]   <= {REG_ADDR_W{1'b0}};
            mem_carry_r[i]  <= 1'b0;
            mem_zero_r[i]   <= 1'b0;
            mem_neg_r[i]    <= 1'b0;
            mem_wr_en_r[i]  <= 1'b0;
         end
      end else if (push_s && !flush) begin
         mem_result_r[wr_ptr_r] <= in_result;
         mem_dest_r[wr_ptr_r]   <= in_dest;
         mem_carry_r[wr_ptr_r]  <= in_carry;
         mem_zero_r[wr_ptr_r]   <= is_zero(in_result);
         mem_neg_r[wr_ptr_r]    <= in_result[ALU_SIZE-1];
         mem_wr_en_r[wr_ptr_r]  <= guard_wr_en(in_wr_en, in_dest);
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_result_r[i] <= mem_result_r[i];
            mem_dest_r[i]   <= mem_dest_r[i];
            mem_carry_r[i]  <= mem_carry_r[i];
            mem_zero_r[i]   <= mem_zero_r[i];
            mem_neg_r[i]    <= mem_neg_r[i];
            mem_wr_en_r[i]  <= mem_wr_en_r[i];
         end
      end
   end

`ifdef ALU_RESULT_QUEUE_FWD_EN
   logic [PTR_W-1:0] fwd_idx_s;

   // Walk oldest to youngest so the last match written is the youngest producer.
   always_comb begin
      fwd_hit_a  = 1'b0;
      fwd_hit_b  = 1'b0;
      fwd_data_a = {ALU_SIZE{1'b0}};
      fwd_data_b = {ALU_SIZE{1'b0}};
      fwd_idx_s  = rd_ptr_r;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx_s = rd_ptr_r + PTR_W'(i);
         if ((CNT_W'(i) < count_r) && mem_wr_en_r[fwd_idx_s]) begin
            if ((mem_dest_r[fwd_idx_s] == fwd_addr_a) && (fwd_addr_a != {REG_ADDR_W{1'b0}})) begin
               fwd_hit_a  = 1'b1;
               fwd_data_a = mem_result_r[fwd_idx_s];
            end else begin
               fwd_hit_a  = fwd_hit_a;
            end
            if ((mem_dest_r[fwd_idx_s] == fwd_addr_b) && (fwd_addr_b != {REG_ADDR_W{1'b0}})) begin
               fwd_hit_b  = 1'b1;
               fwd_data_b = mem_result_r[fwd_idx_s];
            end else begin
               fwd_hit_b  = fwd_hit_b;
            end
         end else begin
            fwd_hit_a = fwd_hit_a;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed self-checking bench for alu_result_queue (forwarding checks when ALU_RESULT_QUEUE_FWD_EN is defined).
`timescale 1ns/1ps
module tb_alu_result_queue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_result;
   logic       in_carry;
   logic [4:0] in_dest;
   logic       in_wr_en;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_result;
   logic       out_carry;
   logic       out_zero;
   logic       out_neg;
   logic [4:0] out_dest;
   logic       out_wr_en;
   logic [1:0] count;
`ifdef ALU_RESULT_QUEUE_FWD_EN
   logic [4:0] fwd_addr_a;
   logic [4:0] fwd_addr_b;
   logic       fwd_hit_a;
   logic       fwd_hit_b;
   logic [7:0] fwd_data_a;
   logic [7:0] fwd_data_b;
`endif

   int tests = 0;
   int fails = 0;

   alu_result_queue #(.ALU_SIZE(8), .REG_ADDR_W(5), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_carry(in_carry), .in_dest(in_dest), .in_wr_en(in_wr_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_carry(out_carry), .out_zero(out_zero), .out_neg(out_neg),
      .out_dest(out_dest), .out_wr_en(out_wr_en),
`ifdef ALU_RESULT_QUEUE_FWD_EN
      .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
      .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
      .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
`endif
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_result = 8'h00;
      in_carry = 1'b0; in_dest = 5'd0; in_wr_en = 1'b0; out_ready = 1'b0;
`ifdef ALU_RESULT_QUEUE_FWD_EN
      fwd_addr_a = 5'd0; fwd_addr_b = 5'd0;
`endif
      #2;
      check("rst_count", 32'(count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", 32'(out_result), 32'h0);
      check("rst_out_wr_en", 32'(out_wr_en), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // single zero-result push, drained immediately
      in_valid = 1'b1; in_result = 8'h00; in_dest = 5'd3; in_wr_en = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_out_zero", 32'(out_zero), 32'd1);
      check("t1_out_neg", 32'(out_neg), 32'd0);
      check("t1_out_dest", 32'(out_dest), 32'd3);
      check("t1_out_wr_en", 32'(out_wr_en), 32'd1);
      check("t1_count", 32'(count), 32'd1);
      step();
      check("t1_drain_valid", 32'(out_valid), 32'd0);
      check("t1_drain_count", 32'(count), 32'd0);

      // fill, ignored push while full, ordered drain
      out_ready = 1'b0;
      in_valid = 1'b1; in_result = 8'h80; in_carry = 1'b1; in_dest = 5'd1;
      step();
      in_result = 8'h05; in_carry = 1'b0; in_dest = 5'd2;
      step();
      check("t2_count_full", 32'(count), 32'd2);
      check("t2_in_ready_full", 32'(in_ready), 32'd0);
      in_result = 8'h11; in_dest = 5'd9;
      step();
      check("t2_count_hold", 32'(count), 32'd2);
      check("t2_head_result", 32'(out_result), 32'h80);
      check("t2_head_neg", 32'(out_neg), 32'd1);
      check("t2_head_carry", 32'(out_carry), 32'd1);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      check("t2_second_result", 32'(out_result), 32'h05);
      check("t2_second_dest", 32'(out_dest), 32'd2);
      check("t2_count_one", 32'(count), 32'd1);
      step();
      check("t2_empty_valid", 32'(out_valid), 32'd0);
      check("t2_empty_count", 32'(count), 32'd0);

      // streaming push+pop at occupancy one, pointers wrap repeatedly
      in_valid = 1'b1; in_result = 8'd1; in_dest = 5'd6; in_wr_en = 1'b1;
      step();
      check("t3_first", 32'(out_result), 32'd1);
      for (int v = 2; v <= 10; v++) begin
         in_result = 8'(v);
         step();
         check("t3_stream_result", 32'(out_result), 32'(v));
         check("t3_stream_count", 32'(count), 32'd1);
      end
      in_valid = 1'b0;
      step();
      check("t3_end_count", 32'(count), 32'd0);

      // r0 guard
      out_ready = 1'b0;
      in_valid = 1'b1; in_result = 8'hFF; in_dest = 5'd0; in_wr_en = 1'b1;
      step();
      in_valid = 1'b0;
      check("t4_wr_en_r0", 32'(out_wr_en), 32'd0);
      check("t4_neg", 32'(out_neg), 32'd1);
      check("t4_result", 32'(out_result), 32'hFF);
      check("t4_zero", 32'(out_zero), 32'd0);
      out_ready = 1'b1;
      step();
      check("t4_drain_count", 32'(count), 32'd0);

      // flush beats a simultaneous push and pop
      out_ready = 1'b0;
      in_valid = 1'b1; in_result = 8'h31; in_dest = 5'd5;
      step();
      in_result = 8'h32;
      step();
      check("t5_full", 32'(count), 32'd2);
      flush = 1'b1; in_result = 8'h22; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("t5_flush_count", 32'(count), 32'd0);
      check("t5_flush_valid", 32'(out_valid), 32'd0);
      check("t5_flush_ready", 32'(in_ready), 32'd1);
      step();
      check("t5_no_22_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      in_valid = 1'b1; in_result = 8'h44; in_dest = 5'd7;
      step();
      in_valid = 1'b0;
      check("t5_post_result", 32'(out_result), 32'h44);
      check("t5_post_count", 32'(count), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // youngest-producer forwarding, then asynchronous reset mid-cycle
      in_valid = 1'b1; in_result = 8'h10; in_dest = 5'd4; in_wr_en = 1'b1;
      step();
      in_result = 8'h20;
      step();
      in_valid = 1'b0;
      check("t6_count", 32'(count), 32'd2);
`ifdef ALU_RESULT_QUEUE_FWD_EN
      fwd_addr_a = 5'd4; fwd_addr_b = 5'd0;
      #1;
      check("t6_hit_a", 32'(fwd_hit_a), 32'd1);
      check("t6_data_a", 32'(fwd_data_a), 32'h20);
      check("t6_hit_b", 32'(fwd_hit_b), 32'd0);
      check("t6_data_b", 32'(fwd_data_b), 32'h0);
      fwd_addr_b = 5'd7;
      #1;
      check("t6_miss_b", 32'(fwd_hit_b), 32'd0);
`endif
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_rst_count", 32'(count), 32'd0);
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_result", 32'(out_result), 32'h0);
      check("t6_rst_dest", 32'(out_dest), 32'd0);
      check("t6_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_RESULT_QUEUE_FWD_EN
      check("t6_rst_fwd_hit_a", 32'(fwd_hit_a), 32'd0);
      check("t6_rst_fwd_data_a", 32'(fwd_data_a), 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
